// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: reads one instruction a byte at a time from a byte-wide memory,
// assembles it little-endian and hands it to IF/ID over a valid/ready handshake.
module if_fetch_unit #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int BYTES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    output logic              fetch_stall_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i
);

    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state_r;
    logic [CNT_W-1:0]    byte_cnt_r;
    logic [ADDR_W-1:0]   base_r;
    logic                mem_req_r;
    logic [ADDR_W-1:0]   mem_addr_r;
    logic [INST_W-1:0]   inst_r;
    logic [ADDR_W-1:0]   inst_pc_r;
    logic                inst_valid_r;

    logic                pc_ready_s;
    logic                accept_s;
    logic                last_byte_s;
    logic [ADDR_W-1:0]   next_addr_s;

    // Acceptance of a new fetch address; a flush always blocks acceptance.
    always_comb begin
        pc_ready_s = 1'b0;
        if (flush_i) begin
            pc_ready_s = 1'b0;
        end else if (state_r == IDLE) begin
            pc_ready_s = 1'b1;
        end else if (state_r == HOLD) begin
            pc_ready_s = inst_ready_i;
        end else begin
            pc_ready_s = 1'b0;
        end
        accept_s    = pc_valid_i & pc_ready_s;
        last_byte_s = (byte_cnt_r == CNT_W'(BYTES - 1));
        next_addr_s = base_r + ADDR_W'(byte_cnt_r) + ADDR_W'(1);
    end

    // Fetch sequencer: byte collection, result hold and flush handling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            byte_cnt_r   <= {CNT_W{1'b0}};
            base_r       <= {ADDR_W{1'b0}};
            mem_req_r    <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            inst_r       <= {INST_W{1'b0}};
            inst_pc_r    <= {ADDR_W{1'b0}};
            inst_valid_r <= 1'b0;
        end else if (flush_i) begin
            state_r      <= IDLE;
            byte_cnt_r   <= {CNT_W{1'b0}};
            mem_req_r    <= 1'b0;
            inst_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r    <= FETCH;
                        base_r     <= pc_i;
                        byte_cnt_r <= {CNT_W{1'b0}};
                        mem_req_r  <= 1'b1;
                        mem_addr_r <= pc_i;
                    end
                end
                FETCH: begin
                    if (mem_ready_i) begin
                        inst_r[{byte_cnt_r, 3'b000} +: 8] <= mem_rdata_i;
                        if (last_byte_s) begin
                            // Final byte: stop requesting and present the word.
                            state_r      <= HOLD;
                            byte_cnt_r   <= {CNT_W{1'b0}};
                            mem_req_r    <= 1'b0;
                            inst_pc_r    <= base_r;
                            inst_valid_r <= 1'b1;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                            mem_addr_r <= next_addr_s;
                        end
                    end
                end
                HOLD: begin
                    if (inst_ready_i) begin
                        inst_valid_r <= 1'b0;
                        if (accept_s) begin
                            state_r    <= FETCH;
                            base_r     <= pc_i;
                            byte_cnt_r <= {CNT_W{1'b0}};
                            mem_req_r  <= 1'b1;
                            mem_addr_r <= pc_i;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    byte_cnt_r   <= {CNT_W{1'b0}};
                    mem_req_r    <= 1'b0;
                    inst_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc_ready_o    = pc_ready_s;
    assign fetch_stall_o = ~pc_ready_s;
    assign mem_req_o     = mem_req_r;
    assign mem_addr_o    = mem_addr_r;
    assign inst_o        = inst_r;
    assign inst_pc_o     = inst_pc_r;
    assign inst_valid_o  = inst_valid_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by a randomized phase, all checked
// against a transaction-level model of the fetch unit and a byte memory with wait states.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_ready_o;
    logic        fetch_stall_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [7:0]  mem_rdata_i;
    logic        mem_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        inst_ready_i;

    if_fetch_unit #(.ADDR_W(32), .INST_W(32), .BYTES(4)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .fetch_stall_o(fetch_stall_o), .flush_i(flush_i), .mem_req_o(mem_req_o),
        .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;
    int cyc = 0;

    // byte memory image; unlisted addresses read a hash of the address
    logic [7:0] mem_a [logic [31:0]];
    int  wait_cfg = 0;
    bit  rand_wait = 1'b0;
    bit  junk = 1'b0;
    int  ctr = 0;
    int  tgt = 0;

    // transaction-level model of the unit
    bit          m_fetch = 1'b0;
    bit          m_hold = 1'b0;
    logic [31:0] m_pc = 32'h0;
    int          m_k = 0;
    logic [31:0] m_hpc = 32'h0;
    logic [31:0] m_word = 32'h0;
    int          acc_cyc = 0;

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (mem_a.exists(a)) return mem_a[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic acc;
        if (rst || flush_i) begin
            m_fetch = 1'b0;
            m_hold  = 1'b0;
        end else begin
            acc = pc_valid_i && !m_fetch && (!m_hold || inst_ready_i);
            if (m_fetch && mem_ready_i) begin
                m_k++;
                if (m_k == 4) begin
                    m_fetch = 1'b0;
                    m_hold  = 1'b1;
                    m_hpc   = m_pc;
                    m_word  = {mem_rd(m_pc + 32'd3), mem_rd(m_pc + 32'd2),
                               mem_rd(m_pc + 32'd1), mem_rd(m_pc)};
                end
            end else if (m_hold && inst_ready_i) begin
                m_hold = 1'b0;
            end
            if (acc) begin
                m_fetch = 1'b1;
                m_hold  = 1'b0;
                m_pc    = pc_i;
                m_k     = 0;
                acc_cyc = cyc;
            end
        end
    endtask

    task automatic mem_drive();
        if (!mem_req_o) begin
            ctr = 0;
            tgt = rand_wait ? int'($urandom_range(0, 2)) : wait_cfg;
            mem_ready_i = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata_i = 8'($urandom);
        end else begin
            if (mem_ready_i) begin
                ctr = 0;
                tgt = rand_wait ? int'($urandom_range(0, 2)) : wait_cfg;
            end
            if (ctr >= tgt) begin
                mem_ready_i = 1'b1;
                mem_rdata_i = mem_rd(mem_addr_o);
            end else begin
                mem_ready_i = 1'b0;
                mem_rdata_i = 8'($urandom);
                ctr++;
            end
        end
    endtask

    task automatic check_model();
        logic exp_ready;
        exp_ready = !m_fetch && (!m_hold || inst_ready_i) && !flush_i;
        chk("pc_ready", {31'd0, pc_ready_o}, {31'd0, exp_ready});
        chk("fetch_stall", {31'd0, fetch_stall_o}, {31'd0, !exp_ready});
        chk("mem_req", {31'd0, mem_req_o}, {31'd0, m_fetch});
        chk("inst_valid", {31'd0, inst_valid_o}, {31'd0, m_hold});
        if (m_fetch) chk("mem_addr", mem_addr_o, m_pc + 32'(m_k));
        if (m_hold) begin
            chk("inst", inst_o, m_word);
            chk("inst_pc", inst_pc_o, m_hpc);
        end
    endtask

    // one clock: advance model over the edge, then drive new inputs and check
    task automatic cycle(input logic pv, input logic [31:0] pc, input logic fl, input logic ir);
        model_step();
        @(posedge clk);
        cyc++;
        #1;
        pc_valid_i   = pv;
        pc_i         = pc;
        flush_i      = fl;
        inst_ready_i = ir;
        mem_drive();
        #1;
        check_model();
    endtask

    task automatic run_until_valid(input int exp_lat, input string tag);
        for (int i = 0; i < 60; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            chk("stall_busy", {31'd0, fetch_stall_o}, 32'd1);
            if (inst_valid_o === 1'b1) begin
                chk(tag, 32'(cyc - acc_cyc), 32'(exp_lat));
                return;
            end
        end
        chk({tag, "_timeout"}, {31'd0, inst_valid_o}, 32'd1);
    endtask

    initial begin
        rst = 1'b1; pc_i = 32'h0; pc_valid_i = 1'b0; flush_i = 1'b0;
        mem_rdata_i = 8'h0; mem_ready_i = 1'b0; inst_ready_i = 1'b0;
        mem_a[32'h100] = 8'h13; mem_a[32'h101] = 8'h05; mem_a[32'h102] = 8'h10; mem_a[32'h103] = 8'h00;
        mem_a[32'h300] = 8'h11; mem_a[32'h301] = 8'h22; mem_a[32'h302] = 8'h33; mem_a[32'h303] = 8'h44;
        mem_a[32'h400] = 8'hAA; mem_a[32'h401] = 8'hBB; mem_a[32'h402] = 8'hCC; mem_a[32'h403] = 8'hDD;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_inst_pc", inst_pc_o, 32'h0);
        chk("rst_inst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_pc_ready", {31'd0, pc_ready_o}, 32'd1);
        rst = 1'b0;

        // zero-wait fetch of 0x100
        cycle(1'b1, 32'h100, 1'b0, 1'b0);
        run_until_valid(5, "lat_zero_wait");
        chk("t1_inst", inst_o, 32'h0010_0513);
        chk("t1_inst_pc", inst_pc_o, 32'h100);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // two wait states per byte
        wait_cfg = 2;
        cycle(1'b1, 32'h200, 1'b0, 1'b0);
        run_until_valid(13, "lat_wait2");
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        wait_cfg = 0;

        // flush after two bytes, with a request offered in the flush cycle
        cycle(1'b1, 32'h300, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, 32'h700, 1'b1, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        chk("flush_mem_req", {31'd0, mem_req_o}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            chk("flush_no_valid", {31'd0, inst_valid_o}, 32'd0);
        end
        cycle(1'b1, 32'h400, 1'b0, 1'b0);
        run_until_valid(5, "lat_after_flush");
        chk("t3_inst", inst_o, 32'hDDCC_BBAA);
        chk("t3_inst_pc", inst_pc_o, 32'h400);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // downstream back-pressure, then back-to-back accept
        cycle(1'b1, 32'h100, 1'b0, 1'b0);
        run_until_valid(5, "lat_t4");
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b0);
            chk("hold_inst", inst_o, 32'h0010_0513);
            chk("hold_inst_pc", inst_pc_o, 32'h100);
            chk("hold_no_req", {31'd0, mem_req_o}, 32'd0);
        end
        cycle(1'b1, 32'h104, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        chk("b2b_req", {31'd0, mem_req_o}, 32'd1);
        chk("b2b_addr", mem_addr_o, 32'h104);
        run_until_valid(5, "lat_b2b");
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // address wrap
        cycle(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_until_valid(5, "lat_wrap");
        chk("wrap_inst", inst_o, {mem_rd(32'h1), mem_rd(32'h0), mem_rd(32'hFFFF_FFFF), mem_rd(32'hFFFF_FFFE)});
        chk("wrap_inst_pc", inst_pc_o, 32'hFFFF_FFFE);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // asynchronous reset in the middle of a fetch
        cycle(1'b1, 32'h500, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        m_fetch = 1'b0;
        m_hold = 1'b0;
        #1;
        chk("arst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("arst_mem_addr", mem_addr_o, 32'h0);
        chk("arst_inst", inst_o, 32'h0);
        chk("arst_inst_pc", inst_pc_o, 32'h0);
        chk("arst_inst_valid", {31'd0, inst_valid_o}, 32'd0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("arst_pc_ready", {31'd0, pc_ready_o}, 32'd1);
        cycle(1'b1, 32'h600, 1'b0, 1'b0);
        run_until_valid(5, "lat_after_rst");
        cycle(1'b0, 32'h0, 1'b0, 1'b1);

        // randomized traffic with random wait states, flushes and stray ready pulses
        rand_wait = 1'b1;
        junk = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 15) == 0),
                  1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 40; i++) begin
            if (!m_fetch && !m_hold) break;
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
        end
        chk("drain_idle", {31'd0, pc_ready_o}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
